// File: rtl/mini_alu_pkg.sv
// Shared mini-ALU definitions: datapath width and the {ovf, diff} result entry
// exchanged between the subtractor and its result FIFO.
package mini_alu_pkg;
  localparam int ALU_W   = 16;
  localparam int ENTRY_W = ALU_W + 1;

  typedef struct packed {
    logic             ovf;
    logic [ALU_W-1:0] diff;
  } alu_result_t;
endpackage

// File: rtl/mini_alu_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment restarts at one
// so the event that arrives with the clear is not lost.
module mini_alu_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clr)                 count <= inc ? W'(1) : '0;
    else if (inc && count != '1)  count <= count + W'(1);
  end
endmodule

// File: rtl/mini_alu_16bit_sub_result_fifo.sv
// Show-ahead result FIFO behind the 16-bit subtractor, with sticky overflow flag
// and saturating overflow-event counter.
module mini_alu_16bit_sub_result_fifo
  import mini_alu_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter int DEPTH     = 4,
  parameter int OVF_CNT_W = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_diff,
  input  logic                 in_overflow,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_ovf,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic [LW-1:0]        level
);
  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            push, pop, ovf_evt;
  logic [WIDTH:0]  head;

  // Full/empty come from level alone, so in_ready never sees out_ready.
  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ovf_evt   = push & in_overflow;

  // Storage is not reset; the head is masked to zero while empty instead.
  assign head         = out_valid ? mem[rd_ptr] : '0;
  assign out_data     = head[WIDTH-1:0];
  assign out_overflow = head[WIDTH];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_overflow, in_diff};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_sticky <= 1'b0;
    else if (ovf_evt) ovf_sticky <= 1'b1;
    else if (clr_ovf) ovf_sticky <= 1'b0;
  end

  mini_alu_sat_counter #(.W(OVF_CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovf_evt),
    .clr   (clr_ovf),
    .count (ovf_count)
  );
endmodule

// File: tb/tb_mini_alu_16bit_sub_result_fifo.sv
// Bench for the subtractor result FIFO: fixed vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_mini_alu_16bit_sub_result_fifo;
  import mini_alu_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 0, rst = 1;
  logic [15:0] in_diff = 0;
  logic        in_overflow = 0, in_valid = 0, out_ready = 0, clr_ovf = 0;
  logic        in_ready, out_overflow, out_valid, ovf_sticky;
  logic [15:0] out_data;
  logic [7:0]  ovf_count;
  logic [2:0]  level;

  mini_alu_16bit_sub_result_fifo dut (
    .clk(clk), .rst(rst), .in_diff(in_diff), .in_overflow(in_overflow),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .level(level)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference model
  alu_result_t q[$];
  logic        m_sticky = 0;
  int          m_count  = 0;

  typedef struct {
    logic v; logic [15:0] d; logic o; logic r;
    logic e_valid; logic [15:0] e_data; logic e_ovf; logic [2:0] e_level; logic e_rdy;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_update(input logic v, input logic [15:0] d, input logic o,
                          input logic r, input logic c);
    bit do_push, do_pop;
    alu_result_t e;
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.ovf = o; e.diff = d;
      q.push_back(e);
    end
    if (do_push && o) begin
      m_sticky = 1;
      m_count  = c ? 1 : (m_count == 255 ? 255 : m_count + 1);
    end else if (c) begin
      m_sticky = 0;
      m_count  = 0;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic o,
                      input logic r, input logic c);
    in_valid = v; in_diff = d; in_overflow = o; out_ready = r; clr_ovf = c;
    @(posedge clk);
    m_update(v, d, o, r, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    alu_result_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".out_valid"},  32'(out_valid),    32'(q.size() != 0));
    chk({tag, ".out_data"},   32'(out_data),     32'(h.diff));
    chk({tag, ".out_ovf"},    32'(out_overflow), 32'(h.ovf));
    chk({tag, ".level"},      32'(level),        32'(q.size()));
    chk({tag, ".in_ready"},   32'(in_ready),     32'(q.size() != DEPTH));
    chk({tag, ".ovf_sticky"}, 32'(ovf_sticky),   32'(m_sticky));
    chk({tag, ".ovf_count"},  32'(ovf_count),    32'(m_count));
  endtask

  initial begin
    //            v  d         o  r   valid data      ovf lvl rdy
    tbl[0]  = '{1, 16'h0005, 0, 0,  1, 16'h0005, 0, 1, 1};
    tbl[1]  = '{0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0, 1};
    tbl[2]  = '{1, 16'h1111, 0, 0,  1, 16'h1111, 0, 1, 1};
    tbl[3]  = '{1, 16'h2222, 0, 0,  1, 16'h1111, 0, 2, 1};
    tbl[4]  = '{1, 16'h3333, 0, 0,  1, 16'h1111, 0, 3, 1};
    tbl[5]  = '{1, 16'h4444, 0, 0,  1, 16'h1111, 0, 4, 0};
    tbl[6]  = '{1, 16'h5555, 0, 0,  1, 16'h1111, 0, 4, 0};
    tbl[7]  = '{1, 16'h6666, 0, 1,  1, 16'h2222, 0, 3, 1};
    tbl[8]  = '{0, 16'h0000, 0, 1,  1, 16'h3333, 0, 2, 1};
    tbl[9]  = '{0, 16'h0000, 0, 1,  1, 16'h4444, 0, 1, 1};
    tbl[10] = '{0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0, 1};
    tbl[11] = '{1, 16'hABCD, 1, 0,  1, 16'hABCD, 1, 1, 1};
    tbl[12] = '{0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0, 1};

    // reset state
    #12;
    chk("rst.level", 32'(level), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_data", 32'(out_data), 0);
    chk("rst.ovf_sticky", 32'(ovf_sticky), 0);
    chk("rst.ovf_count", 32'(ovf_count), 0);
    rst = 0;
    @(posedge clk); #1;

    // directed table: basic push/pop, fill, blocked push, full+pop, ovf field
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].r, 0);
      chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d.out_ovf", i),   32'(out_overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d.level", i),     32'(level),     32'(tbl[i].e_level));
      chk($sformatf("tbl%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].e_rdy));
    end
    chk("tbl.ovf_count", 32'(ovf_count), 1);
    chk("tbl.ovf_sticky", 32'(ovf_sticky), 1);

    // streaming across pointer wrap: level holds at 1, head is the previous push
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(16'h0A00 + i), 0, 1, 0);
      chk($sformatf("stream%0d.level", i), 32'(level), 1);
      chk($sformatf("stream%0d.data", i), 32'(out_data), 32'(16'h0A00 + i));
    end
    step(0, 0, 0, 1, 0);
    check_model("drain");

    // counter saturation, then clear coinciding with an overflow push
    for (int i = 0; i < 300; i++) step(1, 16'(i), 1, 1, 0);
    chk("sat.ovf_count", 32'(ovf_count), 32'hFF);
    chk("sat.ovf_sticky", 32'(ovf_sticky), 1);
    step(1, 16'h7777, 1, 1, 1);
    chk("clrwin.ovf_count", 32'(ovf_count), 1);
    chk("clrwin.ovf_sticky", 32'(ovf_sticky), 1);
    step(0, 0, 0, 1, 1);
    chk("clr.ovf_count", 32'(ovf_count), 0);
    chk("clr.ovf_sticky", 32'(ovf_sticky), 0);
    check_model("clr");

    // async reset with three entries queued
    for (int i = 0; i < 3; i++) step(1, 16'(16'hC000 + i), 1, 0, 0);
    chk("pre_rst.level", 32'(level), 3);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst.level", 32'(level), 0);
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.in_ready", 32'(in_ready), 1);
    chk("arst.ovf_count", 32'(ovf_count), 0);
    #1 rst = 0;
    q.delete(); m_sticky = 0; m_count = 0;
    step(1, 16'hBEEF, 0, 0, 0);
    chk("post_rst.data", 32'(out_data), 32'hBEEF);
    chk("post_rst.level", 32'(level), 1);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 50, $urandom_range(0, 29) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
